// File: rtl/cell_update_sequencer_if.sv
// Draw-command handshake between the cell update sequencer and the LCD command driver.
// The master holds cmd_* stable while cmd_valid is high; the slave answers with a 1-cycle cmd_done.
interface cell_update_sequencer_if #(
  parameter int CW = 4
);
  logic          cmd_valid;
  logic [CW-1:0] cmd_x;
  logic [CW-1:0] cmd_y;
  logic [2:0]    cmd_code;
  logic          cmd_done;

  modport master (output cmd_valid, cmd_x, cmd_y, cmd_code, input cmd_done);
  modport slave  (input cmd_valid, cmd_x, cmd_y, cmd_code, output cmd_done);
endinterface

// File: rtl/cell_update_sequencer.sv
// Per-frame grid scanner: encodes each cell's object flags, compares against the last drawn code,
// and issues a draw command only for cells that changed (or every cell on a full redraw frame).
//
// state | meaning
// IDLE  | waiting for start_frame, scan position parked at (0,0)
// SCAN  | evaluating one cell per cycle
// ISSUE | draw command pending, waiting for cmd_done
// DONE  | one-cycle frame_done pulse, decide whether next frame is a full redraw
module cell_update_sequencer #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12,
  parameter int CW     = 4
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    start_frame,
  input  logic                    force_redraw,
  input  logic                    snakeHead,
  input  logic                    snakeBody,
  input  logic                    apple,
  input  logic                    border,
  output logic [CW-1:0]           x,
  output logic [CW-1:0]           y,
  cell_update_sequencer_if.master cmd,
  output logic                    busy,
  output logic                    init_cycle,
  output logic                    frame_done
);

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DONE} state_t;

  state_t        state;
  logic          force_pend;
  logic [2:0]    shadow [GRID_H][GRID_W];
  logic [2:0]    code;
  logic          diff;
  logic          last_cell;
  logic [CW-1:0] x_adv;
  logic [CW-1:0] y_adv;

  always_comb begin
    code = 3'b000;
    if (border)         code = 3'b100;
    else if (snakeHead) code = 3'b001;
    else if (snakeBody) code = 3'b010;
    else if (apple)     code = 3'b011;
  end

  always_comb begin
    diff      = (code != shadow[y][x]) || init_cycle;
    last_cell = (x == CW'(GRID_W - 1)) && (y == CW'(GRID_H - 1));
    x_adv     = x + 1'b1;
    y_adv     = y;
    if (x == CW'(GRID_W - 1)) begin
      x_adv = '0;
      y_adv = y + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_x     <= '0;
      cmd.cmd_y     <= '0;
      cmd.cmd_code  <= 3'b000;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      init_cycle    <= 1'b1;
      force_pend    <= 1'b0;
      for (int i = 0; i < GRID_H; i++)
        for (int j = 0; j < GRID_W; j++)
          shadow[i][j] <= 3'b000;
    end else begin
      frame_done <= 1'b0;
      if (force_redraw) force_pend <= 1'b1;
      case (state)
        IDLE: begin
          x <= '0;
          y <= '0;
          if (start_frame) begin
            state <= SCAN;
            busy  <= 1'b1;
            // A pending force only takes effect at frame start, never mid-frame.
            if (force_pend || force_redraw) begin
              init_cycle <= 1'b1;
              force_pend <= 1'b0;
            end
          end
        end
        SCAN: begin
          if (diff) begin
            cmd.cmd_valid <= 1'b1;
            cmd.cmd_x     <= x;
            cmd.cmd_y     <= y;
            cmd.cmd_code  <= code;
            state         <= ISSUE;
          end else if (last_cell) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            x <= x_adv;
            y <= y_adv;
          end
        end
        ISSUE: begin
          if (cmd.cmd_done) begin
            cmd.cmd_valid                 <= 1'b0;
            shadow[cmd.cmd_y][cmd.cmd_x]  <= cmd.cmd_code;
            if (last_cell) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              state <= SCAN;
              x     <= x_adv;
              y     <= y_adv;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          x          <= '0;
          y          <= '0;
          init_cycle <= force_pend || force_redraw;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_update_sequencer.sv
// Scoreboard bench: a grid-level model predicts each frame's draw commands; a monitor acting as
// the LCD driver pops and compares every command the sequencer presents.
module tb_cell_update_sequencer;
  localparam int W  = 16;
  localparam int H  = 12;
  localparam int CW = 4;

  logic          tb_clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start_frame = 1'b0;
  logic          force_redraw = 1'b0;
  logic          snakeHead, snakeBody, apple, border;
  logic [CW-1:0] x, y;
  logic          busy, init_cycle, frame_done;

  cell_update_sequencer_if #(.CW(CW)) cmd_if ();

  cell_update_sequencer #(.GRID_W(W), .GRID_H(H), .CW(CW)) dut (
    .clk(tb_clk), .nrst(nrst), .start_frame(start_frame), .force_redraw(force_redraw),
    .snakeHead(snakeHead), .snakeBody(snakeBody), .apple(apple), .border(border),
    .x(x), .y(y), .cmd(cmd_if), .busy(busy), .init_cycle(init_cycle), .frame_done(frame_done)
  );

  always #5 tb_clk = ~tb_clk;

  typedef struct packed {
    logic [3:0] cx;
    logic [3:0] cy;
    logic [2:0] code;
  } cmd_t;

  // scene bits: {border, head, body, apple}
  logic [3:0] scene [H][W];
  logic [2:0] drawn [H][W];
  cmd_t       exp_q [$];
  bit         model_full, model_force, hold_done;
  int         vectors, miscompares, n_seen, cyc;

  always_comb begin
    {border, snakeHead, snakeBody, apple} = 4'b0000;
    if (y < H) {border, snakeHead, snakeBody, apple} = scene[y][x];
  end

  always @(posedge tb_clk) cyc <= cyc + 1;

  function automatic logic [2:0] enc(input logic [3:0] f);
    if (f[3]) return 3'b100;
    if (f[2]) return 3'b001;
    if (f[1]) return 3'b010;
    if (f[0]) return 3'b011;
    return 3'b000;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: which cells must be redrawn this frame, in row-major order.
  function automatic void predict_frame();
    bit full;
    logic [2:0] c;
    cmd_t e;
    full = model_full || model_force;
    model_full  = 1'b0;
    model_force = 1'b0;
    for (int r = 0; r < H; r++)
      for (int col = 0; col < W; col++) begin
        c = enc(scene[r][col]);
        if (full || c != drawn[r][col]) begin
          e.cx = 4'(col); e.cy = 4'(r); e.code = c;
          exp_q.push_back(e);
          drawn[r][col] = c;
        end
      end
  endfunction

  // LCD-driver stand-in and command monitor.
  initial begin
    cmd_t cur;
    bit   prev_v, cur_ok;
    int   wait_n;
    cmd_if.cmd_done = 1'b0;
    prev_v = 1'b0; cur_ok = 1'b0; wait_n = 0;
    forever begin
      @(negedge tb_clk);
      if (cmd_if.cmd_done) cmd_if.cmd_done = 1'b0;
      if (cmd_if.cmd_valid && !prev_v) begin
        n_seen++;
        if (exp_q.size() == 0) begin
          vectors++; miscompares++; cur_ok = 1'b0;
          $display("FAIL unexpected_cmd: got x=%0d y=%0d code=%0d expected none",
                   cmd_if.cmd_x, cmd_if.cmd_y, cmd_if.cmd_code);
        end else begin
          cur = exp_q.pop_front();
          cur_ok = 1'b1;
          check("cmd", int'({cmd_if.cmd_x, cmd_if.cmd_y, cmd_if.cmd_code}), int'(cur));
        end
        wait_n = $urandom_range(0, 3);
      end else if (cmd_if.cmd_valid && cur_ok) begin
        check("cmd_stable", int'({cmd_if.cmd_x, cmd_if.cmd_y, cmd_if.cmd_code}), int'(cur));
        check("xy_hold", int'({x, y}), int'({cur.cx, cur.cy}));
      end
      if (cmd_if.cmd_valid && !hold_done) begin
        if (wait_n == 0) cmd_if.cmd_done = 1'b1;
        else wait_n--;
      end
      prev_v = cmd_if.cmd_valid;
    end
  end

  task automatic cycle();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"}, int'(x), 0);
    check({tag, "_y"}, int'(y), 0);
    check({tag, "_cmd_valid"}, int'(cmd_if.cmd_valid), 0);
    check({tag, "_cmd_xyc"}, int'({cmd_if.cmd_x, cmd_if.cmd_y, cmd_if.cmd_code}), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_init_cycle"}, int'(init_cycle), 1);
  endtask

  task automatic run_frame(input bit check_time, input bit hold50, input bit force_mid);
    int n_exp, t0, t_fd;
    bit got, held;
    predict_frame();
    n_exp = exp_q.size();
    n_seen = 0; got = 1'b0; held = 1'b0; t_fd = 0;
    hold_done = hold50;
    start_frame = 1'b1;
    t0 = cyc;
    cycle();
    start_frame = 1'b0;
    for (int i = 0; i < 6000 && !got; i++) begin
      if (force_mid && i == 20) begin force_redraw = 1'b1; model_force = 1'b1; end
      if (force_mid && i == 21) force_redraw = 1'b0;
      if (hold50 && !held && cmd_if.cmd_valid) begin
        held = 1'b1;
        for (int j = 0; j < 50; j++) begin
          start_frame = (j == 10);
          check("hold_busy", int'(busy), 1);
          cycle();
        end
        start_frame = 1'b0;
        hold_done = 1'b0;
      end
      if (frame_done) begin got = 1'b1; t_fd = cyc; end
      else cycle();
    end
    hold_done = 1'b0;
    check("frame_done_seen", int'(got), 1);
    if (!got) begin
      $display("FAIL frame_timeout: frame_done not seen within bound");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "frame timeout");
    end
    check("cmd_count", n_seen, n_exp);
    check("queue_empty", exp_q.size(), 0);
    if (check_time) check("frame_time", t_fd - t0, W * H + 2);
    check("init_cycle_after", int'(init_cycle), int'(model_force));
    cycle();
    check("frame_done_pulse", int'(frame_done), 0);
    cycle(); cycle();
    check("idle_busy", int'(busy), 0);
    check("idle_no_done", int'(frame_done), 0);
  endtask

  task automatic random_scene_edit(input int n);
    for (int k = 0; k < n; k++)
      scene[$urandom_range(0, H - 1)][$urandom_range(0, W - 1)] = 4'($urandom_range(0, 15));
  endtask

  initial begin
    int bound;
    vectors = 0; miscompares = 0; n_seen = 0; cyc = 0;
    hold_done = 1'b0; model_full = 1'b1; model_force = 1'b0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        scene[r][c] = 4'b0000;
        drawn[r][c] = 3'b000;
      end

    cycle(); cycle();
    check_reset_outputs("reset");
    nrst = 1'b1;
    cycle();

    // Frame 1: empty grid, full redraw
    run_frame(1'b0, 1'b0, 1'b0);

    // Frame 2: border ring plus head at (4,4)
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) scene[r][c] = 4'b1000;
    scene[4][4] = 4'b0100;
    run_frame(1'b0, 1'b0, 1'b0);

    // Frame 3: unchanged, minimum frame time
    run_frame(1'b1, 1'b0, 1'b0);

    // Frame 4: head moves right
    scene[4][4] = 4'b0000;
    scene[4][5] = 4'b0100;
    run_frame(1'b0, 1'b0, 1'b0);

    // Random scene edits
    for (int r = 0; r < 3; r++) begin
      random_scene_edit(int'($urandom_range(5, 25)));
      run_frame(1'b0, 1'b0, 1'b0);
    end

    // Long stall on the first command; start_frame during it is ignored
    scene[2][3] = 4'b0001;
    random_scene_edit(6);
    run_frame(1'b0, 1'b1, 1'b0);

    // force_redraw mid-frame: current frame normal, next frame full
    scene[6][7] = 4'b0010;
    random_scene_edit(4);
    run_frame(1'b0, 1'b0, 1'b1);
    run_frame(1'b0, 1'b0, 1'b0);

    // Reset in the middle of ISSUE
    scene[8][9] = (scene[8][9] == 4'b0001) ? 4'b0010 : 4'b0001;
    predict_frame();
    hold_done = 1'b1;
    start_frame = 1'b1;
    cycle();
    start_frame = 1'b0;
    bound = 0;
    while (!cmd_if.cmd_valid && bound < 400) begin cycle(); bound++; end
    check("issue_reached", int'(cmd_if.cmd_valid), 1);
    cycle(); cycle();
    nrst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) drawn[r][c] = 3'b000;
    model_full = 1'b1; model_force = 1'b0;
    hold_done = 1'b0;
    cycle();
    nrst = 1'b1;
    cycle();
    run_frame(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "global timeout");
  end
endmodule
